// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: feeds one bit per cycle to an external 1-bit ALU slice,
// collects result bits and carries, and finalises arithmetic/compare results.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  input  logic [2:0]       bonus,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [3:0]       slice_control,
  output logic [2:0]       slice_bonus,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ctrl_q;
  logic [2:0]       bonus_q;
  logic [IW-1:0]    i_q;
  logic             carry_q;
  logic [WIDTH-2:0] shadow_q;
  logic             busy_q, done_q, zero_q, ovf_q;
  logic [WIDTH-1:0] result_q;

  logic             run, last;
  logic [WIDTH-1:0] shadow_full, result_d;
  logic             arith, supported, ovf_d, zero_d, lt, z, cond;

  assign run  = (state_q == RUN);
  assign last = (i_q == IW'(WIDTH - 1));

  assign slice_a       = run & a_q[i_q];
  assign slice_b       = run & b_q[i_q];
  assign slice_cin     = run & carry_q;
  assign slice_less    = 1'b0;
  assign slice_bonus   = 3'b000;
  assign slice_control = !run ? 4'b0000 : ((ctrl_q == 4'b0111) ? 4'b0110 : ctrl_q);

  // Final-cycle view: the MSB comes straight from the slice so the result can be
  // registered on the same edge that enters DONE.
  always_comb begin
    shadow_full = {slice_result, shadow_q};
    arith       = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110) || (ctrl_q == 4'b0111);
    supported   = arith || (ctrl_q == 4'b0000) || (ctrl_q == 4'b0001) ||
                  (ctrl_q == 4'b1100) || (ctrl_q == 4'b1101);
    ovf_d       = arith & (carry_q ^ slice_cout);
    lt          = shadow_full[WIDTH-1] ^ ovf_d;
    z           = (shadow_full == '0);
    cond        = 1'b0;
    case (bonus_q)
      3'b000:  cond = lt;
      3'b001:  cond = !lt && !z;
      3'b010:  cond = lt || z;
      3'b011:  cond = !lt;
      3'b110:  cond = z;
      3'b100:  cond = !z;
      default: cond = 1'b0;
    endcase
    if (!supported)
      result_d = '0;
    else if (ctrl_q == 4'b0111)
      result_d = {{(WIDTH-1){1'b0}}, cond};
    else
      result_d = shadow_full;
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      bonus_q  <= '0;
      i_q      <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            ctrl_q  <= control;
            bonus_q <= bonus;
            i_q     <= '0;
            carry_q <= (control == 4'b0110) || (control == 4'b0111);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= slice_cout;
          i_q     <= i_q + 1'b1;
          if (!last) begin
            shadow_q[i_q] <= slice_result;
          end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= supported & ovf_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule
